// File: rtl/id_stage_reg_if.sv
// ID/EX pipeline register bundle: ID-side inputs, EX-side outputs and stage controls.
interface id_stage_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
);
  logic                  flush;
  logic                  freeze;
  logic                  validIn;
  logic [8:0]            controlIn;
  logic [DATA_W-1:0]     pcIn;
  logic [DATA_W-1:0]     valRnIn;
  logic [DATA_W-1:0]     valRmIn;
  logic                  immIn;
  logic [11:0]           shiftOperandIn;
  logic [23:0]           signedImm24In;
  logic [REG_ADDR_W-1:0] destIn;
  logic [REG_ADDR_W-1:0] src1In;
  logic [REG_ADDR_W-1:0] src2In;
  logic                  carryIn;

  logic                  validOut;
  logic [3:0]            exeCmdOut;
  logic                  memReadEnOut;
  logic                  memWriteEnOut;
  logic                  writeBackEnOut;
  logic                  bOut;
  logic                  sOut;
  logic [DATA_W-1:0]     pcOut;
  logic [DATA_W-1:0]     valRnOut;
  logic [DATA_W-1:0]     valRmOut;
  logic                  immOut;
  logic [11:0]           shiftOperandOut;
  logic [23:0]           signedImm24Out;
  logic [REG_ADDR_W-1:0] destOut;
  logic [REG_ADDR_W-1:0] src1Out;
  logic [REG_ADDR_W-1:0] src2Out;
  logic                  carryOut;

  // ID stage / hazard unit side
  modport master (
    output flush, freeze, validIn, controlIn, pcIn, valRnIn, valRmIn, immIn,
           shiftOperandIn, signedImm24In, destIn, src1In, src2In, carryIn,
    input  validOut, exeCmdOut, memReadEnOut, memWriteEnOut, writeBackEnOut,
           bOut, sOut, pcOut, valRnOut, valRmOut, immOut, shiftOperandOut,
           signedImm24Out, destOut, src1Out, src2Out, carryOut
  );

  // Pipeline register side
  modport slave (
    input  flush, freeze, validIn, controlIn, pcIn, valRnIn, valRmIn, immIn,
           shiftOperandIn, signedImm24In, destIn, src1In, src2In, carryIn,
    output validOut, exeCmdOut, memReadEnOut, memWriteEnOut, writeBackEnOut,
           bOut, sOut, pcOut, valRnOut, valRmOut, immOut, shiftOperandOut,
           signedImm24Out, destOut, src1Out, src2Out, carryOut
  );
endinterface

// File: rtl/id_stage_reg.sv
// ID/EX pipeline register: captures decoded control, operands and tags for EX.
// Priority per edge: rst > flush > freeze > load. Outputs come straight from flops.
module id_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input logic          clk,
  input logic          rst,
  id_stage_reg_if.slave bus
);

  logic                  validQ;
  logic [8:0]            controlQ;
  logic [DATA_W-1:0]     pcQ;
  logic [DATA_W-1:0]     valRnQ;
  logic [DATA_W-1:0]     valRmQ;
  logic                  immQ;
  logic [11:0]           shiftOperandQ;
  logic [23:0]           signedImm24Q;
  logic [REG_ADDR_W-1:0] destQ;
  logic [REG_ADDR_W-1:0] src1Q;
  logic [REG_ADDR_W-1:0] src2Q;
  logic                  carryQ;

  // Register update: reset/flush load a bubble, freeze holds, otherwise capture ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validQ        <= 1'b0;
      controlQ      <= '0;
      pcQ           <= '0;
      valRnQ        <= '0;
      valRmQ        <= '0;
      immQ          <= 1'b0;
      shiftOperandQ <= '0;
      signedImm24Q  <= '0;
      destQ         <= '0;
      src1Q         <= '0;
      src2Q         <= '0;
      carryQ        <= 1'b0;
    end else if (bus.flush) begin
      // Flush wins over freeze so a taken-branch bubble is never lost to a stall.
      validQ        <= 1'b0;
      controlQ      <= '0;
      pcQ           <= '0;
      valRnQ        <= '0;
      valRmQ        <= '0;
      immQ          <= 1'b0;
      shiftOperandQ <= '0;
      signedImm24Q  <= '0;
      destQ         <= '0;
      src1Q         <= '0;
      src2Q         <= '0;
      carryQ        <= 1'b0;
    end else if (!bus.freeze) begin
      validQ        <= bus.validIn;
      controlQ      <= bus.controlIn;
      pcQ           <= bus.pcIn;
      valRnQ        <= bus.valRnIn;
      valRmQ        <= bus.valRmIn;
      immQ          <= bus.immIn;
      shiftOperandQ <= bus.shiftOperandIn;
      signedImm24Q  <= bus.signedImm24In;
      destQ         <= bus.destIn;
      src1Q         <= bus.src1In;
      src2Q         <= bus.src2In;
      carryQ        <= bus.carryIn;
    end
  end

  // Control word fields are passed bit-exact; ID already zeroes them for bubbles.
  assign bus.validOut        = validQ;
  assign bus.exeCmdOut       = controlQ[8:5];
  assign bus.memReadEnOut    = controlQ[4];
  assign bus.memWriteEnOut   = controlQ[3];
  assign bus.writeBackEnOut  = controlQ[2];
  assign bus.bOut            = controlQ[1];
  assign bus.sOut            = controlQ[0];
  assign bus.pcOut           = pcQ;
  assign bus.valRnOut        = valRnQ;
  assign bus.valRmOut        = valRmQ;
  assign bus.immOut          = immQ;
  assign bus.shiftOperandOut = shiftOperandQ;
  assign bus.signedImm24Out  = signedImm24Q;
  assign bus.destOut         = destQ;
  assign bus.src1Out         = src1Q;
  assign bus.src2Out         = src2Q;
  assign bus.carryOut        = carryQ;

endmodule

// File: tb/tb_id_stage_reg.sv
// Bench for id_stage_reg: directed scenarios plus a random rst/flush/freeze mix
// against a whole-bundle reference register.
module tb_id_stage_reg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam int BW         = 156;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_stage_reg_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

  id_stage_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [BW-1:0] inVec, outVec, expVec;
  logic [4:0]    enVec;
  int unsigned   total = 0;
  int unsigned   bad   = 0;
  logic [DATA_W-1:0] pcQueue[$];

  assign inVec = {bus.validIn, bus.controlIn, bus.pcIn, bus.valRnIn, bus.valRmIn,
                  bus.immIn, bus.shiftOperandIn, bus.signedImm24In, bus.destIn,
                  bus.src1In, bus.src2In, bus.carryIn};
  assign outVec = {bus.validOut, bus.exeCmdOut, bus.memReadEnOut, bus.memWriteEnOut,
                   bus.writeBackEnOut, bus.bOut, bus.sOut, bus.pcOut, bus.valRnOut,
                   bus.valRmOut, bus.immOut, bus.shiftOperandOut, bus.signedImm24Out,
                   bus.destOut, bus.src1Out, bus.src2Out, bus.carryOut};
  assign enVec = {bus.memReadEnOut, bus.memWriteEnOut, bus.writeBackEnOut, bus.bOut, bus.sOut};

  task automatic checkVal(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic zeroIns();
    bus.validIn = 1'b0; bus.controlIn = '0; bus.pcIn = '0; bus.valRnIn = '0;
    bus.valRmIn = '0; bus.immIn = 1'b0; bus.shiftOperandIn = '0;
    bus.signedImm24In = '0; bus.destIn = '0; bus.src1In = '0; bus.src2In = '0;
    bus.carryIn = 1'b0;
  endtask

  // Random instruction; an invalid slot arrives with a zeroed control word.
  task automatic randIns();
    bus.validIn        = 1'($urandom_range(0, 3) != 0);
    bus.controlIn      = bus.validIn ? 9'($urandom) : 9'd0;
    bus.pcIn           = $urandom;
    bus.valRnIn        = $urandom;
    bus.valRmIn        = $urandom;
    bus.immIn          = 1'($urandom);
    bus.shiftOperandIn = 12'($urandom);
    bus.signedImm24In  = 24'($urandom);
    bus.destIn         = 4'($urandom);
    bus.src1In         = 4'($urandom);
    bus.src2In         = 4'($urandom);
    bus.carryIn        = 1'($urandom);
  endtask

  // One clock: reference register update at the edge, DUT sampled 1ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst || bus.flush) expVec = '0;
    else if (!bus.freeze) expVec = inVec;
    #1;
    checkVal(tag, outVec, expVec);
    if (!bus.validOut) checkVal({tag, "_enIdle"}, BW'(enVec), '0);
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.freeze = 1'b0;
    zeroIns();
    expVec = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkVal("resetInit", outVec, '0);
    rst = 1'b0;

    // 1: async reset mid-cycle over nonzero state
    randIns();
    bus.validIn = 1'b1;
    bus.controlIn = 9'b0010_1_0_1_0_0;
    tick("preReset");
    #3;
    rst = 1'b1;
    #1;
    checkVal("asyncReset", outVec, '0);
    zeroIns();
    tick("resetHeld");
    rst = 1'b0;
    tick("afterRelease");

    // 2: single ADD,S load
    bus.validIn = 1'b1;
    bus.controlIn = 9'b0010_0_0_1_0_1;
    bus.pcIn = 32'h10;
    bus.destIn = 4'd3;
    tick("loadAdd");
    checkVal("addExeCmd", BW'(bus.exeCmdOut), BW'(4'b0010));
    checkVal("addWb", BW'(bus.writeBackEnOut), BW'(1'b1));
    checkVal("addS", BW'(bus.sOut), BW'(1'b1));
    checkVal("addPc", BW'(bus.pcOut), BW'(32'h10));
    checkVal("addDest", BW'(bus.destOut), BW'(4'd3));
    checkVal("addValid", BW'(bus.validOut), BW'(1'b1));

    // 3: LDR held through 3 frozen edges while inputs churn
    randIns();
    bus.validIn = 1'b1;
    bus.controlIn = 9'b0010_1_0_1_0_0;
    bus.pcIn = 32'h200;
    tick("loadLdr");
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randIns();
      tick("freezeHold");
      checkVal("freezeLdrCmd", BW'({bus.exeCmdOut, bus.memReadEnOut, bus.writeBackEnOut}),
               BW'(6'b0010_1_1));
      checkVal("freezeLdrPc", BW'(bus.pcOut), BW'(32'h200));
    end
    bus.freeze = 1'b0;
    randIns();
    tick("unfreeze");

    // 4: flush beats freeze with a valid STR waiting
    bus.validIn = 1'b1;
    bus.controlIn = 9'b0010_0_1_0_0_0;
    bus.pcIn = 32'h44;
    tick("loadStr");
    bus.pcIn = 32'h48;
    bus.flush = 1'b1;
    bus.freeze = 1'b1;
    tick("flushOverFreeze");
    checkVal("flushValid", BW'(bus.validOut), BW'(1'b0));
    checkVal("flushMemWrite", BW'(bus.memWriteEnOut), BW'(1'b0));
    bus.flush = 1'b0;
    bus.freeze = 1'b0;

    // 5: 8-instruction stream, order checked via a PC queue
    for (int i = 0; i < 8; i++) begin
      randIns();
      bus.validIn = 1'b1;
      bus.pcIn = 32'h1000 + 32'(i) * 4;
      pcQueue.push_back(bus.pcIn);
      tick("stream");
      checkVal("streamOrder", BW'(bus.pcOut), BW'(pcQueue.pop_front()));
    end

    // 6: random mix
    for (int i = 0; i < 400; i++) begin
      randIns();
      bus.flush  = 1'($urandom_range(0, 7) == 0);
      bus.freeze = 1'($urandom_range(0, 3) == 0);
      rst        = 1'($urandom_range(0, 29) == 0);
      tick("random");
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
